// File: rtl/c2sif_arb_bridge.sv
// c2sif_arb_bridge: N_CH four-phase req/ack channels, synchronised and arbitrated
// round-robin onto one valid/ready command port, with a response timeout.
module c2sif_arb_bridge #(
   parameter int  N_CH        = 4,
   parameter int  DATA_SIZE   = 4,
   parameter int  TIMEOUT_CYC = 1024,
   parameter int  SYNC_STAGES = 2,
   localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_CH-1:0]               ch_req,
   output logic [N_CH-1:0]               ch_ack,
   input  logic [N_CH*32-1:0]            ch_id,
   input  logic [N_CH*32-1:0]            ch_fn,
   input  logic [N_CH*32-1:0]            ch_addr,
   input  logic [N_CH*DATA_SIZE*32-1:0]  ch_data,
   output logic [N_CH*32-1:0]            ch_ret,
   output logic                          cmd_valid,
   input  logic                          cmd_ready,
   output logic [CH_W-1:0]               cmd_ch,
   output logic [31:0]                   cmd_id,
   output logic [31:0]                   cmd_fn,
   output logic [31:0]                   cmd_addr,
   output logic [DATA_SIZE*32-1:0]       cmd_data,
   input  logic                          rsp_valid,
   input  logic signed [31:0]            rsp_ret,
   output logic                          timeout_pulse,
   output logic                          busy
);
   localparam int DW    = DATA_SIZE * 32;
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
   localparam bit   TO_EN = (TIMEOUT_CYC != 0);

   typedef enum logic [1:0] {IDLE, CMD, WAIT, ACK} state_t;

   state_t                 state_q, state_d;
   logic [CH_W-1:0]        rr_q, rr_d;
   logic [CH_W-1:0]        sel_q, sel_d;
   logic [31:0]            id_q, id_d, fn_q, fn_d, addr_q, addr_d;
   logic [DW-1:0]          data_q, data_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [N_CH-1:0]        ack_q, ack_d;
   logic                   pulse_q, pulse_d;
   logic [31:0]            ret_q [N_CH];
   logic [31:0]            ret_d [N_CH];
   logic [SYNC_STAGES-1:0] sync_q [N_CH];
   logic [SYNC_STAGES-1:0] sync_d [N_CH];
   logic [N_CH-1:0]        req_s;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         assign sync_d[gi]          = {sync_q[gi][SYNC_STAGES-2:0], ch_req[gi]};
         assign req_s[gi]           = sync_q[gi][SYNC_STAGES-1];
         assign ch_ret[gi*32 +: 32] = ret_q[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CH; c++) sync_q[c] <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   // Round-robin scan: first requester at or above rr_q, wrapping; acked channels are skipped.
   logic            grant_found;
   logic [CH_W-1:0] grant_idx;
   logic [CH_W:0]   scan_sum;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_sum    = '0;
      for (int i = 0; i < N_CH; i++) begin
         scan_sum = {1'b0, rr_q} + (CH_W+1)'(i);
         if (scan_sum >= (CH_W+1)'(N_CH)) scan_sum = scan_sum - (CH_W+1)'(N_CH);
         if (!grant_found && req_s[scan_sum[CH_W-1:0]] && !ack_q[scan_sum[CH_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan_sum[CH_W-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      sel_d   = sel_q;
      id_d    = id_q;
      fn_d    = fn_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      ack_d   = ack_q;
      ret_d   = ret_q;
      pulse_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               sel_d   = grant_idx;
               id_d    = ch_id[grant_idx*32 +: 32];
               fn_d    = ch_fn[grant_idx*32 +: 32];
               addr_d  = ch_addr[grant_idx*32 +: 32];
               data_d  = ch_data[grant_idx*DW +: DW];
               rr_d    = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);
               state_d = CMD;
            end
         end
         CMD: begin
            if (cmd_ready) begin
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A response arriving on the timeout cycle takes priority over the timeout.
            if (rsp_valid) begin
               ret_d[sel_q] = rsp_ret;
               ack_d[sel_q] = 1'b1;
               state_d      = ACK;
            end else if (TO_EN && cnt_q == CNT_LAST) begin
               ret_d[sel_q] = 32'hFFFF_FFFF;
               ack_d[sel_q] = 1'b1;
               pulse_d      = 1'b1;
               state_d      = ACK;
            end
         end
         ACK: begin
            if (!req_s[sel_q]) begin
               ack_d[sel_q] = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_q    <= '0;
         sel_q   <= '0;
         id_q    <= '0;
         fn_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         ack_q   <= '0;
         pulse_q <= 1'b0;
         for (int c = 0; c < N_CH; c++) ret_q[c] <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         sel_q   <= sel_d;
         id_q    <= id_d;
         fn_q    <= fn_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         pulse_q <= pulse_d;
         ret_q   <= ret_d;
      end
   end

   assign ch_ack        = ack_q;
   assign cmd_valid     = (state_q == CMD);
   assign cmd_ch        = sel_q;
   assign cmd_id        = id_q;
   assign cmd_fn        = fn_q;
   assign cmd_addr      = addr_q;
   assign cmd_data      = data_q;
   assign timeout_pulse = pulse_q;
   assign busy          = (state_q != IDLE);
endmodule
